// File: rtl/riscv_32_decode_stage.sv
// Purpose : RV32 decode stage; splits raw fields, builds the format immediate, flags unsupported encodings.
// Latency : 1 cycle from input accept to out_valid when the output register is empty.
// Backpressure: valid/ready; SKID=1 adds a second entry so in_ready is a flop, SKID=0 makes in_ready combinational.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   flush                    synchronous clear of every buffered entry (beats all transfers)
//   in_valid/in_ready/in_instr    instruction input handshake
//   out_valid/out_ready/out_instr decoded entry handshake plus its raw instruction
//   opcode, funct3, funct7, rs1, rs2, rd   raw fields sliced from out_instr
//   imm, fmt, illegal        decoded immediate, format code (R0 I1 S2 B3 U4 J5 ILL7), illegal flag
//   instr_count, illegal_count    saturating counts of output transfers / illegal output transfers
module riscv_32_decode_stage #(
  parameter int CNT_W       = 16,
  parameter int SKID        = 1,
  parameter int SUPPORT_CSR = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [6:0]       opcode,
  output logic [2:0]       funct3,
  output logic [6:0]       funct7,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic [31:0]      imm,
  output logic [2:0]       fmt,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] illegal_count
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // One buffered entry: everything the output needs, decoded at capture so
  // the output side is nothing but flops.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        illegal;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] i);
    dec_t d;
    d.instr   = i;
    d.imm     = '0;
    d.fmt     = FMT_ILL;
    d.illegal = 1'b0;
    case (i[6:0])
      7'b0110011: begin
        // Only the base (0000000) and SUB/SRA (0100000) funct7 values are legal.
        if (i[31:25] == 7'b0000000 || i[31:25] == 7'b0100000) d.fmt = FMT_R;
      end
      7'b0010011, 7'b0000011, 7'b1100111: d.fmt = FMT_I;
      7'b0100011: d.fmt = FMT_S;
      7'b1100011: d.fmt = FMT_B;
      7'b0110111, 7'b0010111: d.fmt = FMT_U;
      7'b1101111: d.fmt = FMT_J;
      7'b1110011: d.fmt = (SUPPORT_CSR != 0) ? FMT_I : FMT_ILL;
      default:    d.fmt = FMT_ILL;
    endcase
    case (d.fmt)
      FMT_I:   d.imm = {{20{i[31]}}, i[31:20]};
      FMT_S:   d.imm = {{20{i[31]}}, i[31:25], i[11:7]};
      FMT_B:   d.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      FMT_U:   d.imm = {i[31:12], 12'b0};
      FMT_J:   d.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: d.imm = '0;  // R and ILL carry no immediate
    endcase
    d.illegal = (d.fmt == FMT_ILL);
    return d;
  endfunction

  dec_t in_dec;
  dec_t out_q;
  dec_t skid_q;
  logic out_vld_q;
  logic skid_vld_q;
  logic in_xfer;
  logic out_xfer;
  logic out_free;

  assign in_dec = decode(in_instr);

  generate
    if (SKID != 0) begin : g_skid_rdy
      // skid_vld_q is a flop, so in_ready has no combinational path from out_ready.
      assign in_ready = !skid_vld_q;
    end else begin : g_reg_rdy
      assign in_ready = !out_vld_q || out_ready;
    end
  endgenerate

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_vld_q && out_ready;
  // The output register can be (re)loaded this cycle.
  assign out_free = !out_vld_q || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q      <= '0;
      skid_q     <= '0;
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
    end else if (flush) begin
      // Payload is left as-is; only the valid bits matter once cleared.
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
    end else if (out_free) begin
      if (skid_vld_q) begin
        // Older skid entry goes first. in_ready was low, so nothing new arrives.
        out_q      <= skid_q;
        out_vld_q  <= 1'b1;
        skid_vld_q <= 1'b0;
      end else if (in_xfer) begin
        // Covers both empty output and simultaneous drain+accept (no bubble).
        out_q     <= in_dec;
        out_vld_q <= 1'b1;
      end else begin
        out_vld_q <= 1'b0;
      end
    end else if ((SKID != 0) && in_xfer) begin
      // Output stalled: park the new instruction behind it.
      skid_q     <= in_dec;
      skid_vld_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_count   <= '0;
      illegal_count <= '0;
    end else if (out_xfer && !flush) begin
      if (instr_count != CNT_MAX) instr_count <= instr_count + CNT_W'(1);
      if (out_q.illegal && illegal_count != CNT_MAX) illegal_count <= illegal_count + CNT_W'(1);
    end
  end

  assign out_valid = out_vld_q;
  assign out_instr = out_q.instr;
  assign opcode    = out_q.instr[6:0];
  assign rd        = out_q.instr[11:7];
  assign funct3    = out_q.instr[14:12];
  assign rs1       = out_q.instr[19:15];
  assign rs2       = out_q.instr[24:20];
  assign funct7    = out_q.instr[31:25];
  assign imm       = out_q.imm;
  assign fmt       = out_q.fmt;
  assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_riscv_32_decode_stage.sv
module tb_riscv_32_decode_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;

  // Instance A: defaults (SKID=1, SUPPORT_CSR=1, CNT_W=16)
  logic        a_in_ready, a_out_valid, a_illegal;
  logic [31:0] a_out_instr, a_imm;
  logic [6:0]  a_opcode, a_funct7;
  logic [2:0]  a_funct3, a_fmt;
  logic [4:0]  a_rs1, a_rs2, a_rd;
  logic [15:0] a_icnt, a_lcnt;

  // Instance B: SKID=0, SUPPORT_CSR=0, CNT_W=4
  logic        b_in_ready, b_out_valid, b_illegal;
  logic [31:0] b_out_instr, b_imm;
  logic [6:0]  b_opcode, b_funct7;
  logic [2:0]  b_funct3, b_fmt;
  logic [4:0]  b_rs1, b_rs2, b_rd;
  logic [3:0]  b_icnt, b_lcnt;

  always #5 clk = ~clk;

  riscv_32_decode_stage dut_a (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_instr(in_instr),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_instr(a_out_instr),
    .opcode(a_opcode), .funct3(a_funct3), .funct7(a_funct7),
    .rs1(a_rs1), .rs2(a_rs2), .rd(a_rd),
    .imm(a_imm), .fmt(a_fmt), .illegal(a_illegal),
    .instr_count(a_icnt), .illegal_count(a_lcnt)
  );

  riscv_32_decode_stage #(.CNT_W(4), .SKID(0), .SUPPORT_CSR(0)) dut_b (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_instr(b_out_instr),
    .opcode(b_opcode), .funct3(b_funct3), .funct7(b_funct7),
    .rs1(b_rs1), .rs2(b_rs2), .rd(b_rd),
    .imm(b_imm), .fmt(b_fmt), .illegal(b_illegal),
    .instr_count(b_icnt), .illegal_count(b_lcnt)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference decode: format from the opcode table, immediate as a signed integer
  // assembled by weighting each instruction field.
  function automatic void ref_dec(input logic [31:0] x, input bit csr,
                                  output logic [2:0] f, output logic [31:0] im);
    int v;
    f = 3'd7;
    case (x[6:0])
      7'h33: f = (x[31:25] == 7'h00 || x[31:25] == 7'h20) ? 3'd0 : 3'd7;
      7'h13, 7'h03, 7'h67: f = 3'd1;
      7'h23: f = 3'd2;
      7'h63: f = 3'd3;
      7'h37, 7'h17: f = 3'd4;
      7'h6F: f = 3'd5;
      7'h73: f = csr ? 3'd1 : 3'd7;
      default: f = 3'd7;
    endcase
    case (f)
      3'd1: v = int'(x[30:20]) - int'(x[31]) * 2048;
      3'd2: v = int'(x[30:25]) * 32 + int'(x[11:7]) - int'(x[31]) * 2048;
      3'd3: v = int'(x[11:8]) * 2 + int'(x[30:25]) * 32 + int'(x[7]) * 2048 - int'(x[31]) * 4096;
      3'd4: v = int'(x & 32'hFFFF_F000);
      3'd5: v = int'(x[30:21]) * 2 + int'(x[20]) * 2048 + int'(x[19:12]) * 4096 - int'(x[31]) * 1048576;
      default: v = 0;
    endcase
    im = 32'(v);
  endfunction

  // Model per instance: a FIFO of raw instructions (index 0 is on the output).
  logic [31:0] mq [2][2];
  int          mn  [2];
  int          mic [2];
  int          mil [2];

  function automatic bit exp_rdy(input int k);
    if (k == 0) return mn[0] < 2;
    return (mn[1] == 0) || out_ready;
  endfunction

  task automatic step(input int k);
    bit          ir, ox;
    logic [2:0]  f;
    logic [31:0] im;
    int          cmax;
    cmax = (k == 0) ? 65535 : 15;
    ir = exp_rdy(k);
    ox = (mn[k] > 0) && out_ready;
    if (flush) begin
      mn[k] = 0;
    end else begin
      if (ox) begin
        ref_dec(mq[k][0], k == 0, f, im);
        if (mic[k] < cmax) mic[k]++;
        if (f == 3'd7 && mil[k] < cmax) mil[k]++;
        mq[k][0] = mq[k][1];
        mn[k]--;
      end
      if (in_valid && ir) begin
        mq[k][mn[k]] = in_instr;
        mn[k]++;
      end
    end
  endtask

  task automatic check_inst(input int k);
    logic        ov, ir, il;
    logic [31:0] oi, im, e, eim;
    logic [6:0]  op, f7;
    logic [2:0]  f3, f;
    logic [2:0]  ef;
    logic [4:0]  r1, r2, rdv;
    int          ic, lc;
    string       p;
    if (k == 0) begin
      p = "A "; ov = a_out_valid; ir = a_in_ready; il = a_illegal; oi = a_out_instr; im = a_imm;
      op = a_opcode; f7 = a_funct7; f3 = a_funct3; f = a_fmt; r1 = a_rs1; r2 = a_rs2; rdv = a_rd;
      ic = int'(a_icnt); lc = int'(a_lcnt);
    end else begin
      p = "B "; ov = b_out_valid; ir = b_in_ready; il = b_illegal; oi = b_out_instr; im = b_imm;
      op = b_opcode; f7 = b_funct7; f3 = b_funct3; f = b_fmt; r1 = b_rs1; r2 = b_rs2; rdv = b_rd;
      ic = int'(b_icnt); lc = int'(b_lcnt);
    end
    chk({p, "out_valid"}, ov, mn[k] > 0);
    chk({p, "in_ready"}, ir, exp_rdy(k));
    if (mn[k] > 0) begin
      e = mq[k][0];
      ref_dec(e, k == 0, ef, eim);
      chk({p, "out_instr"}, oi, e);
      chk({p, "fmt"}, f, ef);
      chk({p, "imm"}, im, eim);
      chk({p, "illegal"}, il, ef == 3'd7);
      chk({p, "fields"}, {op, f3, f7, r1, r2, rdv}, {e[6:0], e[14:12], e[31:25], e[19:15], e[24:20], e[11:7]});
    end
    chk({p, "instr_count"}, ic, mic[k]);
    chk({p, "illegal_count"}, lc, mil[k]);
  endtask

  task automatic cycle(input logic v, input logic [31:0] ins, input logic ordy, input logic fl);
    @(negedge clk);
    check_inst(0);
    check_inst(1);
    in_valid = v; in_instr = ins; out_ready = ordy; flush = fl;
    @(posedge clk);
    step(0);
    step(1);
  endtask

  // mid=1: assert reset between edges while traffic is live and check the async clear.
  task automatic do_reset(input bit mid);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst A out_valid", a_out_valid, 1'b0);
    chk("rst B out_valid", b_out_valid, 1'b0);
    chk("rst A counts", {a_icnt, a_lcnt}, 32'h0);
    chk("rst B counts", {b_icnt, b_lcnt}, 8'h0);
    if (!mid) begin
      chk("rst A in_ready", a_in_ready, 1'b1);
      chk("rst A out_instr", a_out_instr, 32'h0);
      chk("rst A imm/fmt/illegal", {a_imm, a_fmt, a_illegal}, 36'h0);
      chk("rst A fields", {a_opcode, a_funct3, a_funct7, a_rs1, a_rs2, a_rd}, 32'h0);
    end
    for (int k = 0; k < 2; k++) begin
      mn[k] = 0; mic[k] = 0; mil[k] = 0;
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73};

  function automatic logic [31:0] rnd_instr();
    logic [31:0] x;
    int sel;
    sel = $urandom_range(0, 11);
    x = $urandom;
    if (sel < 10) begin
      x[6:0] = ops[sel];
      if (sel == 0 && $urandom_range(0, 3) != 0) x[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    end else if (sel == 11) begin
      x = 32'h0;
    end
    return x;
  endfunction

  initial begin
    for (int k = 0; k < 2; k++) begin
      mn[k] = 0; mic[k] = 0; mil[k] = 0;
    end

    // Reset state, then addi / beq / jal
    do_reset(0);
    cycle(1'b1, 32'h0050_0093, 1'b1, 1'b0);
    #1;
    chk("addi valid/fmt/illegal", {a_out_valid, a_fmt, a_illegal}, {1'b1, 3'd1, 1'b0});
    chk("addi rd/rs1", {a_rd, a_rs1}, {5'd1, 5'd0});
    chk("addi imm", a_imm, 32'h0000_0005);
    cycle(1'b1, 32'hFE00_0EE3, 1'b1, 1'b0);
    #1;
    chk("beq fmt/imm", {a_fmt, a_imm}, {3'd3, 32'hFFFF_FFFC});
    cycle(1'b1, 32'h0080_00EF, 1'b1, 1'b0);
    #1;
    chk("jal fmt/imm/rd", {a_fmt, a_imm, a_rd}, {3'd5, 32'h0000_0008, 5'd1});
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Stall with A,B,C, then drain in order
    do_reset(0);
    cycle(1'b1, 32'h0011_0113, 1'b0, 1'b0);
    cycle(1'b1, 32'h0022_0233, 1'b0, 1'b0);
    cycle(1'b1, 32'h0033_0313, 1'b0, 1'b0);
    #1;
    chk("stall A on output", a_out_instr, 32'h0011_0113);
    chk("stall in_ready low", a_in_ready, 1'b0);
    cycle(1'b1, 32'h0033_0313, 1'b1, 1'b0);
    #1;
    chk("drain 2nd", a_out_instr, 32'h0022_0233);
    cycle(1'b1, 32'h0033_0313, 1'b1, 1'b0);
    #1;
    chk("drain 3rd", {a_out_valid, a_out_instr}, {1'b1, 32'h0033_0313});
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    #1;
    chk("drain instr_count", a_icnt, 16'd3);

    // All-zero word and csrrw: both illegal without CSR support
    do_reset(0);
    cycle(1'b1, 32'h0000_0000, 1'b1, 1'b0);
    cycle(1'b1, 32'h3402_9073, 1'b1, 1'b0);
    #1;
    chk("B csrrw illegal/fmt/imm", {b_illegal, b_fmt, b_imm}, {1'b1, 3'd7, 32'h0});
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    #1;
    chk("B illegal_count", b_lcnt, 4'd2);

    // Flush with output and skid full, output transfer in the flush cycle
    do_reset(0);
    cycle(1'b1, 32'h0010_0093, 1'b0, 1'b0);
    cycle(1'b1, 32'h0020_0093, 1'b0, 1'b0);
    cycle(1'b1, 32'h0030_0093, 1'b1, 1'b1);
    #1;
    chk("flush out_valid/in_ready", {a_out_valid, a_in_ready}, 2'b01);
    chk("flush counters", {a_icnt, a_lcnt}, 32'h0);

    // Saturation on the 4-bit counters
    do_reset(0);
    for (int i = 0; i < 20; i++) cycle(1'b1, rnd_instr(), 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    #1;
    chk("B instr_count saturated", b_icnt, 4'd15);
    chk("A instr_count 20", a_icnt, 16'd20);
    for (int i = 0; i < 3; i++) cycle(1'b1, rnd_instr(), 1'b1, 1'b0);
    do_reset(1);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 3) != 0, rnd_instr(), $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
